// File: rtl/niu_pkg.sv
// Shared types and helpers for the NIU TX arbitration path.
package niu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

    localparam int ARB_RR     = 0;
    localparam int ARB_STRICT = 1;

    // First valid channel at or after ptr, wrapping at num_ch; ptr = 0 gives lowest-index priority.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int unsigned num_ch);
        logic [2:0] win;
        logic       found;
        logic [3:0] idx;
        win   = 3'd0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = 4'({1'b0, ptr} + 4'(i));
            if (32'(idx) >= num_ch) begin
                idx = 4'(32'(idx) - num_ch);
            end else begin
                idx = idx;
            end
            if (!found && (i < num_ch) && valid[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/niu_act_led.sv
// Activity stretcher: any beat reloads the counter, the LED stays lit until it bleeds to zero.
module niu_act_led
    import niu_pkg::*;
#(
    parameter int LED_W = 24
) (
    input  logic clk156,
    input  logic aresetn,
    input  logic beat,
    output logic act
);

    logic [LED_W-1:0] cnt_r;
    logic             act_r;

    // Stretch counter: reload on beat, otherwise count down to zero
    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            cnt_r <= '0;
        end else if (beat) begin
            cnt_r <= '1;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - LED_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered LED: tracks whether the counter will be non-zero after this edge
    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            act_r <= 1'b0;
        end else begin
            act_r <= beat | (cnt_r > LED_W'(1));
        end
    end

    assign act = act_r;

endmodule

// File: rtl/niu_tx_arbiter.sv
// N:1 packet-level AXI-Stream arbiter in front of the 10GBASE-R MAC TX stream,
// with grant lock per packet, flush on link loss, frame/drop counters and activity LEDs.
module niu_tx_arbiter
    import niu_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int DATA_W   = 64,
    parameter  int ARB_MODE = ARB_RR,
    parameter  int CNT_W    = 32,
    parameter  int LED_W    = 24,
    localparam int GW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int KW       = DATA_W / 8
) (
    input  logic                     clk156,
    input  logic                     aresetn,
    input  logic                     link_up,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH*KW-1:0]     s_axis_tkeep,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KW-1:0]            m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [GW-1:0]            grant_ch,
    output logic [NUM_CH*CNT_W-1:0]  frame_cnt,
    output logic [15:0]              drop_cnt,
    output logic [NUM_CH-1:0]        led_act
);

    arb_state_t        state_r;
    logic [GW-1:0]     grant_r;
    logic [GW-1:0]     rr_ptr_r;
    logic [CNT_W-1:0]  frame_cnt_r [NUM_CH];
    logic [15:0]       drop_cnt_r;

    logic [GW-1:0]     pick_s;
    logic [GW-1:0]     next_ptr_s;
    logic [7:0]        valid_ext_s;
    logic [2:0]        ptr_ext_s;
    logic              sel_valid_s;
    logic              sel_last_s;
    logic              sent_last_s;
    logic              flushed_last_s;
    logic [NUM_CH-1:0] ready_s;
    logic [NUM_CH-1:0] beat_s;

    // Arbitration winner and pointer advance; strict mode always searches from channel 0
    always_comb begin
        valid_ext_s = 8'(s_axis_tvalid);
        ptr_ext_s   = (ARB_MODE == ARB_STRICT) ? 3'd0 : 3'(rr_ptr_r);
        pick_s      = GW'(rr_pick(valid_ext_s, ptr_ext_s, 32'(NUM_CH)));
        next_ptr_s  = (grant_r == GW'(NUM_CH - 1)) ? '0 : grant_r + GW'(1);
    end

    // Unregistered pass-through of the granted channel; readies depend on state
    always_comb begin
        m_axis_tdata  = s_axis_tdata[grant_r*DATA_W +: DATA_W];
        m_axis_tkeep  = s_axis_tkeep[grant_r*KW +: KW];
        m_axis_tlast  = s_axis_tlast[grant_r];
        sel_valid_s   = s_axis_tvalid[grant_r];
        sel_last_s    = s_axis_tlast[grant_r];
        ready_s       = '0;
        case (state_r)
            ST_BUSY:  ready_s[grant_r] = m_axis_tready;
            ST_FLUSH: ready_s[grant_r] = 1'b1;
            default:  ready_s = '0;
        endcase
        m_axis_tvalid  = (state_r == ST_BUSY) && sel_valid_s;
        sent_last_s    = m_axis_tvalid && m_axis_tready && sel_last_s;
        flushed_last_s = (state_r == ST_FLUSH) && sel_valid_s && sel_last_s;
        s_axis_tready  = ready_s;
        beat_s         = s_axis_tvalid & ready_s;
    end

    // Packet FSM: grant in IDLE, lock through tlast, drain the source if the link drops
    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            rr_ptr_r   <= '0;
            drop_cnt_r <= 16'd0;
            for (int i = 0; i < NUM_CH; i++) begin
                frame_cnt_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (link_up && (|s_axis_tvalid)) begin
                        grant_r <= pick_s;
                        state_r <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                // A tlast handshake wins over a simultaneous link drop
                ST_BUSY: begin
                    if (sent_last_s) begin
                        frame_cnt_r[grant_r] <= frame_cnt_r[grant_r] + CNT_W'(1);
                        rr_ptr_r             <= next_ptr_s;
                        state_r              <= ST_IDLE;
                    end else if (!link_up) begin
                        state_r <= ST_FLUSH;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_FLUSH: begin
                    if (flushed_last_s) begin
                        if (drop_cnt_r != 16'hFFFF) begin
                            drop_cnt_r <= drop_cnt_r + 16'd1;
                        end else begin
                            drop_cnt_r <= drop_cnt_r;
                        end
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            frame_cnt[i*CNT_W +: CNT_W] = frame_cnt_r[i];
        end
    end

    assign grant_ch = grant_r;
    assign drop_cnt = drop_cnt_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_led
        niu_act_led #(.LED_W(LED_W)) u_led (
            .clk156  (clk156),
            .aresetn (aresetn),
            .beat    (beat_s[g]),
            .act     (led_act[g])
        );
    end

endmodule

// File: tb/tb_niu_tx_arbiter.sv
// Scoreboard bench for niu_tx_arbiter: round-robin instance for the main flows,
// a strict-priority instance for lowest-index-wins behaviour.
`timescale 1ns/1ps
module tb_niu_tx_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int CW  = 32;

    typedef struct packed {
        logic [1:0]  ch;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic              clk156 = 1'b0;
    logic              aresetn;
    logic              link_up;
    logic [NCH*DW-1:0] s_tdata;
    logic [NCH*KW-1:0] s_tkeep;
    logic [NCH-1:0]    s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid, m_tlast, m_tready;
    logic [1:0]        grant_ch;
    logic [NCH*CW-1:0] frame_cnt;
    logic [15:0]       drop_cnt;
    logic [NCH-1:0]    led_act;

    logic              link_b;
    logic [NCH*DW-1:0] s_tdata_b;
    logic [NCH*KW-1:0] s_tkeep_b;
    logic [NCH-1:0]    s_tvalid_b, s_tlast_b, s_tready_b;
    logic [DW-1:0]     m_tdata_b;
    logic [KW-1:0]     m_tkeep_b;
    logic              m_tvalid_b, m_tlast_b, m_tready_b;
    logic [1:0]        grant_b;
    logic [NCH*CW-1:0] frame_cnt_b;
    logic [15:0]       drop_b;
    logic [NCH-1:0]    led_b;

    int     checks   = 0;
    int     errors   = 0;
    int     fire_cnt = 0;
    beat_t  src_q [NCH][$];
    beat_t  exp_q [$];
    logic [NCH-1:0] fired = '0;
    logic   prev_last = 1'b0;

    niu_tx_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .ARB_MODE(0), .CNT_W(CW), .LED_W(4)) dut (
        .clk156(clk156), .aresetn(aresetn), .link_up(link_up),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .grant_ch(grant_ch), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .led_act(led_act)
    );

    niu_tx_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .ARB_MODE(1), .CNT_W(CW), .LED_W(4)) dut_b (
        .clk156(clk156), .aresetn(aresetn), .link_up(link_b),
        .s_axis_tdata(s_tdata_b), .s_axis_tkeep(s_tkeep_b), .s_axis_tvalid(s_tvalid_b),
        .s_axis_tlast(s_tlast_b), .s_axis_tready(s_tready_b),
        .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tvalid(m_tvalid_b),
        .m_axis_tlast(m_tlast_b), .m_axis_tready(m_tready_b),
        .grant_ch(grant_b), .frame_cnt(frame_cnt_b), .drop_cnt(drop_b), .led_act(led_b)
    );

    always #4 clk156 = ~clk156;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input int ch, input int frm, input int nbeats, input int nexp);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.ch   = 2'(ch);
            b.data = 64'hC0DE_0000_0000_0000 | (64'(ch) << 16) | (64'(frm) << 8) | 64'(i);
            b.keep = (i == nbeats - 1) ? 8'h0F : 8'hFF;
            b.last = (i == nbeats - 1);
            src_q[ch].push_back(b);
            if (i < nexp) exp_q.push_back(b);
        end
    endtask

    task automatic wait_fires(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (fire_cnt < target && n < budget) begin
            @(posedge clk156); #1;
            n++;
        end
        chk(name, 64'(fire_cnt >= target), 64'd1);
    endtask

    // Source models: one queue per channel, advance on an observed handshake
    initial begin
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
        forever begin
            @(posedge clk156); #1;
            for (int c = 0; c < NCH; c++) begin
                if (fired[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
                if (src_q[c].size() > 0) begin
                    s_tvalid[c]          = 1'b1;
                    s_tdata[c*DW +: DW]  = src_q[c][0].data;
                    s_tkeep[c*KW +: KW]  = src_q[c][0].keep;
                    s_tlast[c]           = src_q[c][0].last;
                end else begin
                    s_tvalid[c]          = 1'b0;
                    s_tdata[c*DW +: DW]  = '0;
                    s_tkeep[c*KW +: KW]  = '0;
                    s_tlast[c]           = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every MAC-side handshake against the scoreboard head
    initial begin
        beat_t e;
        forever begin
            @(negedge clk156);
            fired = s_tvalid & s_tready;
            if (!aresetn) begin
                prev_last = 1'b0;
            end else begin
                if (prev_last) chk("bubble_after_last", 64'(m_tvalid), 64'd0);
                prev_last = 1'b0;
                if (m_tvalid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: actual data=%0h required no beat", m_tdata);
                        if (m_tready) fire_cnt++;
                    end else begin
                        e = exp_q[0];
                        chk("ready_mirror", 64'(s_tready), 64'(m_tready ? (4'b0001 << e.ch) : 4'b0000));
                        if (m_tready) begin
                            void'(exp_q.pop_front());
                            fire_cnt++;
                            chk("beat_grant", 64'(grant_ch), 64'(e.ch));
                            chk("beat_data",  m_tdata, e.data);
                            chk("beat_keep",  64'(m_tkeep), 64'(e.keep));
                            chk("beat_last",  64'(m_tlast), 64'(e.last));
                            prev_last = m_tlast;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int base, n, rem0, rem2;
        logic f0, f2;
        aresetn = 1'b0; link_up = 1'b0; m_tready = 1'b1;
        link_b = 1'b1; s_tdata_b = '0; s_tkeep_b = '0; s_tvalid_b = '0; s_tlast_b = '1; m_tready_b = 1'b1;
        repeat (3) @(posedge clk156);
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_grant",  64'(grant_ch), 64'd0);
        chk("rst_drop",   64'(drop_cnt), 64'd0);
        chk("rst_led",    64'(led_act),  64'd0);
        for (int c = 0; c < NCH; c++) chk("rst_frame_cnt", 64'(frame_cnt[c*CW +: CW]), 64'd0);
        aresetn = 1'b1; link_up = 1'b1;
        @(posedge clk156); #1;

        // Round robin with all four channels loaded: 0,1,2,3,0
        base = fire_cnt;
        send_frame(0, 0, 3, 3); send_frame(1, 0, 3, 3); send_frame(2, 0, 3, 3);
        send_frame(3, 0, 3, 3); send_frame(0, 1, 3, 3);
        wait_fires(base + 12, 60, "rr_four_frames");
        for (int c = 0; c < NCH; c++) chk("rr_frame_cnt", 64'(frame_cnt[c*CW +: CW]), 64'd1);
        wait_fires(base + 15, 20, "rr_fifth_frame");
        chk("rr_frame_cnt0", 64'(frame_cnt[0 +: CW]), 64'd2);
        chk("led_lit", 64'(led_act[0]), 64'd1);
        repeat (20) @(posedge clk156);
        #1;
        chk("led_decayed", 64'(led_act), 64'd0);

        // Strict priority: ch0 and ch2 both pending, ch0 always wins
        rem0 = 5; rem2 = 3;
        s_tvalid_b = 4'b0101;
        for (int cyc = 0; cyc < 80 && (rem0 > 0 || rem2 > 0); cyc++) begin
            @(negedge clk156);
            f0 = s_tvalid_b[0] & s_tready_b[0];
            f2 = s_tvalid_b[2] & s_tready_b[2];
            if (m_tvalid_b) chk("strict_grant", 64'(grant_b), (rem0 > 0) ? 64'd0 : 64'd2);
            @(posedge clk156); #1;
            if (f0) rem0--;
            if (f2) rem2--;
            s_tvalid_b = {1'b0, rem2 > 0, 1'b0, rem0 > 0};
            if (f0 && rem0 == 0) begin
                chk("strict_cnt2_starved", 64'(frame_cnt_b[2*CW +: CW]), 64'd0);
                chk("strict_cnt0", 64'(frame_cnt_b[0 +: CW]), 64'd5);
            end
        end
        chk("strict_done", 64'(rem0 + rem2), 64'd0);
        chk("strict_cnt2", 64'(frame_cnt_b[2*CW +: CW]), 64'd3);

        // Backpressure: m_tready toggles during an 8-beat ch1 frame
        base = fire_cnt;
        send_frame(1, 1, 8, 8);
        n = 0;
        while (fire_cnt < base + 8 && n < 80) begin
            @(posedge clk156); #1;
            m_tready = ~m_tready;
            n++;
        end
        m_tready = 1'b1;
        chk("bp_beats", 64'(fire_cnt - base), 64'd8);
        chk("bp_frame_cnt1", 64'(frame_cnt[1*CW +: CW]), 64'd2);

        // Link loss on the third beat of a 6-beat ch2 frame
        base = fire_cnt;
        send_frame(2, 1, 6, 3);
        wait_fires(base + 2, 40, "flush_start");
        link_up = 1'b0;
        @(negedge clk156);
        @(negedge clk156);
        chk("flush_tvalid", 64'(m_tvalid), 64'd0);
        chk("flush_ready",  64'(s_tready), 64'b0100);
        n = 0;
        while (drop_cnt != 16'd1 && n < 40) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("flush_drop_cnt", 64'(drop_cnt), 64'd1);
        @(posedge clk156); #1;
        chk("flush_drained", 64'(src_q[2].size()), 64'd0);
        chk("flush_frame_cnt2", 64'(frame_cnt[2*CW +: CW]), 64'd1);
        send_frame(0, 2, 2, 2);
        repeat (4) begin
            @(negedge clk156);
            chk("linkdown_no_grant", 64'({m_tvalid, s_tready}), 64'd0);
        end
        @(posedge clk156); #1;
        link_up = 1'b1;
        wait_fires(base + 5, 40, "link_return");

        // tlast handshake in the same cycle link_up falls
        base = fire_cnt;
        send_frame(3, 1, 2, 2);
        wait_fires(base + 1, 40, "simul_first");
        link_up = 1'b0;
        @(posedge clk156); #1;
        chk("simul_frame_cnt3", 64'(frame_cnt[3*CW +: CW]), 64'd2);
        chk("simul_drop_cnt",   64'(drop_cnt), 64'd1);
        @(negedge clk156);
        chk("simul_no_flush", 64'({m_tvalid, s_tready}), 64'd0);
        @(posedge clk156); #1;
        link_up = 1'b1;

        // Asynchronous reset in the middle of a ch1 frame
        base = fire_cnt;
        send_frame(1, 3, 6, 6);
        wait_fires(base + 2, 40, "arst_mid");
        #1;
        aresetn = 1'b0;
        #1;
        chk("arst_tvalid", 64'(m_tvalid), 64'd0);
        chk("arst_tready", 64'(s_tready), 64'd0);
        chk("arst_grant",  64'(grant_ch), 64'd0);
        chk("arst_drop",   64'(drop_cnt), 64'd0);
        chk("arst_led",    64'(led_act),  64'd0);
        for (int c = 0; c < NCH; c++) chk("arst_frame_cnt", 64'(frame_cnt[c*CW +: CW]), 64'd0);
        src_q[1].delete();
        exp_q.delete();
        repeat (2) @(posedge clk156);
        #1;
        aresetn = 1'b1;
        base = fire_cnt;
        send_frame(0, 4, 3, 3);
        wait_fires(base + 3, 40, "post_reset_frame");
        chk("post_reset_frame_cnt0", 64'(frame_cnt[0 +: CW]), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
